// File: rtl/sprite_loader_if.sv
// Byte-stream load handshake and sprite-row read port between the host and sprite_loader.
interface sprite_loader_if #(
  parameter int SN_W = 9
);
  logic            start;
  logic [SN_W-1:0] ld_sprite;
  logic            abort;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            busy;
  logic            done;
  logic            err;
  logic [SN_W-1:0] rd_sprite;
  logic [3:0]      rd_row;
  logic [15:0]     rd_data;

  modport master (
    output start, ld_sprite, abort, in_valid, in_data, rd_sprite, rd_row,
    input  in_ready, busy, done, err, rd_data
  );

  modport slave (
    input  start, ld_sprite, abort, in_valid, in_data, rd_sprite, rd_row,
    output in_ready, busy, done, err, rd_data
  );
endinterface

// File: rtl/sprite_loader.sv
// Loads 16x16 1-bpp sprites from a byte stream into sprite RAM and serves rows to the pixel generators.
// Optional trailing XOR checksum byte: define SPRITE_LOADER_CHECKSUM_EN.
module sprite_loader #(
  parameter int N_SPRITES = 4,
  parameter int SN_W      = 9
) (
  input  logic            clk,
  input  logic            rst,
  sprite_loader_if.slave  io_bus
);
  localparam int SPR_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam logic [SN_W-1:0] NSPR = SN_W'(N_SPRITES);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_CHK, S_FIN} state_t;

  state_t           r_state;
  logic [3:0]       r_row;
  logic [7:0]       r_lo;
  logic [SPR_W-1:0] r_sprite;
  logic             r_done;
  logic             r_err;
  logic [15:0]      r_mem [0:N_SPRITES*16-1];

  logic             w_accept;
  logic             w_wr;
  logic             w_rd_ok;

  assign io_bus.in_ready = (r_state == S_LO) || (r_state == S_HI) || (r_state == S_CHK);
  assign io_bus.busy     = (r_state != S_IDLE);
  assign io_bus.done     = r_done;
  assign io_bus.err      = r_err;
  assign w_accept        = io_bus.in_valid && io_bus.in_ready;
  assign w_wr            = (r_state == S_HI) && w_accept && !io_bus.abort;

`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_csum <= '0;
    else if (r_state == S_IDLE)
      r_csum <= '0;
    else if (w_accept && ((r_state == S_LO) || (r_state == S_HI)))
      r_csum <= r_csum ^ io_bus.in_data;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_lo     <= '0;
      r_sprite <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            if (io_bus.ld_sprite < NSPR) begin
              r_sprite <= io_bus.ld_sprite[SPR_W-1:0];
              r_row    <= '0;
              r_state  <= S_LO;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LO: begin
          if (io_bus.abort) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_lo    <= io_bus.in_data;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          // Abort beats a simultaneous accept: the byte is consumed but the row is not committed.
          if (io_bus.abort) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            if (r_row == 4'd15) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_FIN;
              r_done  <= 1'b1;
`endif
            end else begin
              r_row   <= r_row + 4'd1;
              r_state <= S_LO;
            end
          end
        end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (io_bus.abort) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            if (io_bus.in_data == r_csum) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sprite RAM has no reset so loaded images survive a reset.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[{r_sprite, r_row}] <= {io_bus.in_data, r_lo};
  end

  assign w_rd_ok        = (io_bus.rd_sprite < NSPR);
  assign io_bus.rd_data = w_rd_ok ? r_mem[{io_bus.rd_sprite[SPR_W-1:0], io_bus.rd_row}] : 16'h0000;

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: stimulus queues expected done/err/read events, a monitor checks them.
module tb_sprite_loader;
  localparam int SN_W = 9;

  typedef enum int {EV_DONE, EV_ERR, EV_READ} evKind_t;
  typedef struct {
    evKind_t     kind;
    logic [15:0] value;
    string       name;
  } expItem_t;

  logic clk;
  logic rst;
  logic rdReq;
  int   passCount;
  int   checkCount;
  expItem_t expQueue[$];

  sprite_loader_if #(.SN_W(SN_W)) bus ();

  sprite_loader #(.N_SPRITES(4), .SN_W(SN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direct comparison used for control-output checks made by the stimulus.
  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic pushExp(input evKind_t kind, input logic [15:0] value, input string name);
    expItem_t item;
    item.kind  = kind;
    item.value = value;
    item.name  = name;
    expQueue.push_back(item);
  endtask

  task automatic popCompare(input evKind_t kind, input logic [15:0] actual);
    expItem_t item;
    checkCount++;
    if (expQueue.size() == 0) begin
      $display("[TB] FAIL unexpected %s event: got %h, expected no event", kind.name(), actual);
      return;
    end
    item = expQueue.pop_front();
    if (item.kind != kind)
      $display("[TB] FAIL %s: got event %s, expected event %s", item.name, kind.name(), item.kind.name());
    else if (kind == EV_READ && actual !== item.value)
      $display("[TB] FAIL %s: got %h, expected %h", item.name, actual, item.value);
    else
      passCount++;
  endtask

  // Monitor: every done/err pulse and every requested read consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done === 1'b1) popCompare(EV_DONE, 16'h0);
      if (bus.err === 1'b1)  popCompare(EV_ERR, 16'h0);
      if (rdReq)             popCompare(EV_READ, bus.rd_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [SN_W-1:0] spr);
    bus.start     = 1'b1;
    bus.ld_sprite = spr;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic readCheck(input logic [SN_W-1:0] spr, input logic [3:0] row,
                           input logic [15:0] expected, input string name);
    bus.rd_sprite = spr;
    bus.rd_row    = row;
    pushExp(EV_READ, expected, name);
    rdReq = 1'b1;
    tick();
    rdReq = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waitCount;
    waitCount    = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && waitCount < 50) begin
      tick();
      waitCount++;
    end
    if (!bus.in_ready) begin
      checkCount++;
      $display("[TB] FAIL in_ready timeout: got %b, expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Byte k carries row k/2; even k is the low-column byte.
  task automatic sendPayload(input logic [7:0] hiBase, input logic [7:0] loBase,
                             input int nBytes, input bit gap);
    for (int k = 0; k < nBytes; k++) begin
      if (k % 2 == 0) sendByte(loBase + 8'(k / 2));
      else            sendByte(hiBase + 8'(k / 2));
      if (gap) tick();
    end
  endtask

  task automatic loadFull(input logic [SN_W-1:0] spr, input logic [7:0] hiBase,
                          input logic [7:0] loBase, input bit badCsum);
    logic [7:0] csum;
    csum = 8'h00;
    for (int r = 0; r < 16; r++) csum = csum ^ (loBase + 8'(r)) ^ (hiBase + 8'(r));
    if (badCsum) pushExp(EV_ERR, 16'h0, "checksum err");
    else         pushExp(EV_DONE, 16'h0, "load done");
    applyStimulus(spr);
    sendPayload(hiBase, loBase, 32, 1'b0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    sendByte(badCsum ? (csum ^ 8'h01) : csum);
`endif
    tick();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    passCount     = 0;
    checkCount    = 0;
    rdReq         = 1'b0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.ld_sprite = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.rd_sprite = '0;
    bus.rd_row    = 4'd0;
    repeat (3) tick();
    checkOutput("reset busy",     16'(bus.busy),     16'h0);
    checkOutput("reset in_ready", 16'(bus.in_ready), 16'h0);
    checkOutput("reset done",     16'(bus.done),     16'h0);
    checkOutput("reset err",      16'(bus.err),      16'h0);
    rst = 1'b0;
    tick();

    $display("[TB] full load of sprite 2");
    applyStimulus(9'd2);
    checkOutput("in_ready after start", 16'(bus.in_ready), 16'h1);
    checkOutput("busy after start",     16'(bus.busy),     16'h1);
    expQueue.push_front('{EV_DONE, 16'h0, "sprite2 done"});
    sendPayload(8'hA0, 8'h50, 32, 1'b0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    sendByte(8'h00);
`endif
    repeat (3) tick();
    readCheck(9'd2, 4'd5,  16'hA555, "sprite2 row5");
    readCheck(9'd2, 4'd0,  16'hA050, "sprite2 row0");
    readCheck(9'd2, 4'd15, 16'hAF5F, "sprite2 row15");
    readCheck(9'd4, 4'd5,  16'h0000, "out-of-range sprite4 read");
    readCheck(9'h1FF, 4'd0, 16'h0000, "out-of-range sprite511 read");

    $display("[TB] bad sprite number");
    pushExp(EV_ERR, 16'h0, "bad start err");
    applyStimulus(9'd4);
    checkOutput("busy after bad start", 16'(bus.busy), 16'h0);
    tick();
    checkOutput("err is one cycle", 16'(bus.err), 16'h0);
    readCheck(9'd2, 4'd5, 16'hA555, "sprite2 row5 after bad start");

    $display("[TB] abort of sprite 1 reload");
    loadFull(9'd1, 8'h10, 8'h20, 1'b0);
    applyStimulus(9'd1);
    sendPayload(8'h60, 8'h90, 11, 1'b1);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h65;
    checkOutput("in_ready during abort", 16'(bus.in_ready), 16'h1);
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("busy after abort", 16'(bus.busy), 16'h0);
    repeat (2) tick();
    readCheck(9'd1, 4'd0,  16'h6090, "sprite1 row0 new");
    readCheck(9'd1, 4'd4,  16'h6494, "sprite1 row4 new");
    readCheck(9'd1, 4'd5,  16'h1525, "sprite1 row5 old");
    readCheck(9'd1, 4'd15, 16'h1F2F, "sprite1 row15 old");

    $display("[TB] reset in the middle of a sprite 3 load");
    loadFull(9'd3, 8'h40, 8'h80, 1'b0);
    applyStimulus(9'd3);
    sendPayload(8'hF0, 8'h01, 7, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("busy on mid-load reset",     16'(bus.busy),     16'h0);
    checkOutput("in_ready on mid-load reset", 16'(bus.in_ready), 16'h0);
    tick();
    rst = 1'b0;
    tick();
    readCheck(9'd3, 4'd0,  16'hF001, "sprite3 row0 new");
    readCheck(9'd3, 4'd2,  16'hF203, "sprite3 row2 new");
    readCheck(9'd3, 4'd3,  16'h4383, "sprite3 row3 old");
    readCheck(9'd3, 4'd15, 16'h4F8F, "sprite3 row15 old");
    loadFull(9'd3, 8'h70, 8'hE0, 1'b0);
    readCheck(9'd3, 4'd3,  16'h73E3, "sprite3 row3 reload");
    readCheck(9'd3, 4'd15, 16'h7FEF, "sprite3 row15 reload");

`ifdef SPRITE_LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    loadFull(9'd0, 8'hC0, 8'h30, 1'b0);
    readCheck(9'd0, 4'd7, 16'hC737, "sprite0 row7 good csum");
    loadFull(9'd0, 8'hE0, 8'h70, 1'b1);
    checkOutput("busy after bad csum", 16'(bus.busy), 16'h0);
    readCheck(9'd0, 4'd7, 16'hE777, "sprite0 row7 bad csum");
    readCheck(9'd0, 4'd0, 16'hE070, "sprite0 row0 bad csum");
`endif

    repeat (4) tick();
    checkCount++;
    if (expQueue.size() == 0) passCount++;
    else begin
      while (expQueue.size() != 0) begin
        expItem_t item;
        item = expQueue.pop_front();
        $display("[TB] FAIL %s: got no event, expected %s", item.name, item.kind.name());
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
